fp_window_minmax: RTL and testbench
===================================

// Module: fp_window_minmax
// PURPOSE
//  Streaming IEEE-style float comparator and windowed min/max tracker for envelope and peak
//  detection. Each valid sample is compared against a threshold and folded into a running
//  min/max. Once every WINDOW samples it reports the window extremes. Exponent and mantissa
//  widths are parameters, and NaN inputs produce an explicit unordered result.
// PARAMETERS
//  EXP_W   8     exponent field width
//  MANT_W  23    mantissa field width; word width W = 1+EXP_W+MANT_W
//  WINDOW  256   samples per window, >=2; counter width $clog2(WINDOW)
// PORTS
//  clk        in   1  sole clock, rising edge
//  reset_n    in   1  asynchronous, active-low reset
//  in_valid   in   1  data_in is a sample this cycle
//  data_in    in   W  sample {sign,exp,mant}
//  thresh     in   W  comparison threshold, sampled together with data_in
//  win_clear  in   1  synchronous abort of the current window
//  cmp_valid  out  1  leq/geq/unord valid
//  leq        out  1  data_in <= thresh
//  geq        out  1  data_in >= thresh
//  unord      out  1  data_in or thresh is NaN
//  win_valid  out  1  one-cycle pulse: window complete
//  win_min    out  W  minimum non-NaN sample of the window
//  win_max    out  W  maximum non-NaN sample of the window
//  win_empty  out  1  all samples in the window were NaN (min/max meaningless)
// BEHAVIOUR
//  Reset: every output and internal register goes to 0 (cmp_valid, win_valid, leq, geq, unord,
//   win_min, win_max, win_empty, sample counter, pipeline valids). Assertion mid-window discards it.
//  Classification: NaN = exp all ones and mant != 0. Inf (exp all ones, mant 0) orders normally.
//   +0 and -0 compare equal. Denormals order by bits; no flushing.
//  Ordering key: K(x) = sign ? ~x : x ^ (1<<(W-1)); unsigned compare of K gives float order.
//   Two zeros of either sign are equal, overriding K.
//  Compare pipeline, fixed 2-cycle latency, no backpressure:
//   S1 registers data_in, thresh and in_valid, then decodes NaN/zero flags.
//   S2 registers cmp_valid=S1 valid and the results below.
//   a == b: leq=geq=1.  a < b: leq=1, geq=0.  a > b: leq=0, geq=1.
//   Either operand NaN: leq=geq=0, unord=1; otherwise unord=0.
//   cmp_valid=0 holds leq/geq/unord at their last values.
//  Window tracker runs on S1 data, sampled 1 cycle after in_valid:
//   cnt counts every valid sample, NaN included. cur_min/cur_max/have track non-NaN samples only.
//   A first non-NaN sample (have=0) loads both cur_min and cur_max. Later ones update by key compare.
//   On the sample where cnt==WINDOW-1, in the next cycle, at S2 timing:
//    win_valid=1 for one cycle.
//    win_min/win_max = extremes including that sample.
//    win_empty = !have_including_sample.
//   Same edge: cnt, have, cur_min and cur_max reset, so the next sample opens a new window.
//    There are no gaps.
//   win_min/win_max/win_empty hold between pulses.
//   Min/max ties on equal key keep the stored value. For -0 vs +0, the stored value is kept.
//  win_clear: cnt=0, have=0, and the in-flight S1 sample is dropped from the tracker. No win_valid.
//   It does not affect the compare pipeline.
//   If win_clear is asserted while S1 completes a window, clear wins and no pulse is issued.
//   If win_clear and in_valid arrive in the same cycle, that new sample counts as sample 0 of the
//    new window.
//  Back-to-back in_valid every cycle is supported at full rate.
//  No combinational path from inputs to outputs.
// TESTING
//  Use EXP_W=8, MANT_W=23, WINDOW=4 unless stated.
//  Order: data 3F800000 (1.0) vs thresh BF800000 (-1.0) -> cycle+2: cmp_valid=1, geq=1, leq=0, unord=0.
//   Swapped -> leq=1, geq=0.
//  Zero: 80000000 vs 00000000 -> leq=geq=1.
//   7F800000 (+inf) vs 7F7FFFFF -> geq=1, leq=0.
//  NaN: 7FC00000 vs 3F800000 -> leq=geq=0, unord=1.
//   Window {7FC00000 x4} -> win_valid, win_empty=1.
//  Window: 40000000, C0400000, 7FC00000, 3F000000 on consecutive cycles ->
//   one win_valid pulse 2 cycles after the last sample; win_min=C0400000 (-3.0), win_max=40000000 (2.0), win_empty=0.
//   The 5th sample 3F800000 starts a fresh window.
//  Clear: 2 samples, then win_clear with in_valid (41000000), then 3 more ->
//   exactly one pulse, after the 4th sample counting from the one sent with win_clear.
//   The two pre-clear samples must not appear in min/max.
//  Reset: drop reset_n mid-window after 3 samples -> all outputs 0 immediately.
//   After release, 4 new samples produce a pulse with correct min/max.

Source files
------------

// File: rtl/fp_window_minmax.sv
// Streaming float comparator with a 2-cycle compare pipeline and a tumbling-window
// min/max tracker. NaN samples are counted but never folded into the extremes.
module fp_window_minmax #(
   parameter  int EXP_W  = 8,
   parameter  int MANT_W = 23,
   parameter  int WINDOW = 256,
   localparam int W      = 1 + EXP_W + MANT_W,
   localparam int CNT_W  = $clog2(WINDOW)
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         in_valid,
   input  logic [W-1:0] data_in,
   input  logic [W-1:0] thresh,
   input  logic         win_clear,
   output logic         cmp_valid,
   output logic         leq,
   output logic         geq,
   output logic         unord,
   output logic         win_valid,
   output logic [W-1:0] win_min,
   output logic [W-1:0] win_max,
   output logic         win_empty
);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW - 1);

   // Unsigned order of the key equals float order for all non-NaN encodings.
   function automatic logic [W-1:0] f_key(input logic [W-1:0] x);
      return x[W-1] ? ~x : (x ^ {1'b1, {(W-1){1'b0}}});
   endfunction

   function automatic logic f_is_nan(input logic [W-1:0] x);
      return (&x[W-2:MANT_W]) && (|x[MANT_W-1:0]);
   endfunction

   function automatic logic f_is_zero(input logic [W-1:0] x);
      return ~|x[W-2:0];
   endfunction

   logic         r_s1_valid;
   logic [W-1:0] r_s1_data;
   logic [W-1:0] r_s1_thresh;

   logic         r_cmp_valid, r_leq, r_geq, r_unord;

   logic [CNT_W-1:0] r_cnt;
   logic             r_have;
   logic [W-1:0]     r_cur_min, r_cur_max;
   logic             r_win_valid, r_win_empty;
   logic [W-1:0]     r_win_min, r_win_max;

   logic         w_a_nan, w_b_nan, w_a_zero, w_b_zero;
   logic [W-1:0] w_a_key, w_b_key;
   logic         w_unord, w_eq, w_lt;
   logic         w_lt_min, w_gt_max;
   logic [W-1:0] w_min_inc, w_max_inc;
   logic         w_have_inc, w_win_done;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of block ordering.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_s1_valid  <= 1'b0;
         r_s1_data   <= '0;
         r_s1_thresh <= '0;
      end else begin
         r_s1_valid  <= in_valid;
         r_s1_data   <= data_in;
         r_s1_thresh <= thresh;
      end
   end

   assign w_a_nan  = f_is_nan(r_s1_data);
   assign w_b_nan  = f_is_nan(r_s1_thresh);
   assign w_a_zero = f_is_zero(r_s1_data);
   assign w_b_zero = f_is_zero(r_s1_thresh);
   assign w_a_key  = f_key(r_s1_data);
   assign w_b_key  = f_key(r_s1_thresh);

   assign w_unord = w_a_nan | w_b_nan;
   assign w_eq    = (w_a_zero & w_b_zero) | (w_a_key == w_b_key);
   assign w_lt    = ~w_eq & (w_a_key < w_b_key);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cmp_valid <= 1'b0;
         r_leq       <= 1'b0;
         r_geq       <= 1'b0;
         r_unord     <= 1'b0;
      end else begin
         r_cmp_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_leq   <= ~w_unord & (w_eq | w_lt);
            r_geq   <= ~w_unord & ~w_lt;
            r_unord <= w_unord;
         end
      end
   end

   // Zero-vs-zero is a tie, so the stored zero of either sign is kept.
   assign w_lt_min = ~(w_a_zero & f_is_zero(r_cur_min)) & (w_a_key < f_key(r_cur_min));
   assign w_gt_max = ~(w_a_zero & f_is_zero(r_cur_max)) & (w_a_key > f_key(r_cur_max));

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      w_min_inc  = r_cur_min;
      w_max_inc  = r_cur_max;
      w_have_inc = r_have;
      if (!w_a_nan) begin
         w_have_inc = 1'b1;
         if (!r_have) begin
            w_min_inc = r_s1_data;
            w_max_inc = r_s1_data;
         end else begin
            if (w_lt_min) w_min_inc = r_s1_data;
            if (w_gt_max) w_max_inc = r_s1_data;
         end
      end
   end

   assign w_win_done = r_s1_valid & ~win_clear & (r_cnt == LAST_IDX);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt       <= '0;
         r_have      <= 1'b0;
         r_cur_min   <= '0;
         r_cur_max   <= '0;
         r_win_valid <= 1'b0;
         r_win_min   <= '0;
         r_win_max   <= '0;
         r_win_empty <= 1'b0;
      end else begin
         r_win_valid <= w_win_done;
         if (win_clear) begin
            r_cnt  <= '0;
            r_have <= 1'b0;
         end else if (r_s1_valid) begin
            if (w_win_done) begin
               r_cnt       <= '0;
               r_have      <= 1'b0;
               r_cur_min   <= '0;
               r_cur_max   <= '0;
               r_win_min   <= w_min_inc;
               r_win_max   <= w_max_inc;
               r_win_empty <= ~w_have_inc;
            end else begin
               r_cnt     <= r_cnt + CNT_W'(1);
               r_have    <= w_have_inc;
               r_cur_min <= w_min_inc;
               r_cur_max <= w_max_inc;
            end
         end
      end
   end

   assign cmp_valid = r_cmp_valid;
   assign leq       = r_leq;
   assign geq       = r_geq;
   assign unord     = r_unord;
   assign win_valid = r_win_valid;
   assign win_min   = r_win_min;
   assign win_max   = r_win_max;
   assign win_empty = r_win_empty;

endmodule

// File: tb/tb_fp_window_minmax.sv
// Scoreboard bench for fp_window_minmax: a value-level float model predicts compare
// results and window extremes; a negedge monitor pops and compares them with timing.
module tb_fp_window_minmax;

   localparam int EXP_W  = 8;
   localparam int MANT_W = 23;
   localparam int WINDOW = 4;
   localparam int W      = 1 + EXP_W + MANT_W;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         in_valid;
   logic [W-1:0] data_in;
   logic [W-1:0] thresh;
   logic         win_clear;
   logic         cmp_valid, leq, geq, unord;
   logic         win_valid, win_empty;
   logic [W-1:0] win_min, win_max;

   fp_window_minmax #(.EXP_W(EXP_W), .MANT_W(MANT_W), .WINDOW(WINDOW)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .data_in(data_in),
      .thresh(thresh), .win_clear(win_clear), .cmp_valid(cmp_valid), .leq(leq),
      .geq(geq), .unord(unord), .win_valid(win_valid), .win_min(win_min),
      .win_max(win_max), .win_empty(win_empty)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic leq, geq, unord;
      int   cyc;
   } cmp_exp_t;

   typedef struct {
      logic [W-1:0] mn, mx;
      logic         empty;
      int           cyc;
   } win_exp_t;

   cmp_exp_t     cmp_q[$];
   win_exp_t     win_q[$];
   logic [W-1:0] win_list[$];

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference float semantics: sign/magnitude ordering, both zeros equal.
   function automatic bit is_nan(input logic [W-1:0] x);
      return (x[W-2:MANT_W] == '1) && (x[MANT_W-1:0] != 0);
   endfunction

   function automatic int fcmp(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-2:0] ma, mb;
      ma = a[W-2:0];
      mb = b[W-2:0];
      if (ma == 0 && mb == 0) return 0;
      if (a[W-1] != b[W-1]) return a[W-1] ? -1 : 1;
      if (ma == mb) return 0;
      if (!a[W-1]) return (ma < mb) ? -1 : 1;
      return (ma > mb) ? -1 : 1;
   endfunction

   // One model step per driven cycle: a completed window is only confirmed on the
   // following cycle, because a clear arriving then discards it.
   task automatic step(input bit v, input logic [W-1:0] d, input logic [W-1:0] t, input bit clr);
      cmp_exp_t ce;
      win_exp_t we;
      bit       have;
      if (clr) begin
         win_list.delete();
      end else if (win_list.size() == WINDOW) begin
         have  = 0;
         we.mn = '0;
         we.mx = '0;
         foreach (win_list[i]) begin
            if (!is_nan(win_list[i])) begin
               if (!have) begin
                  we.mn = win_list[i];
                  we.mx = win_list[i];
                  have  = 1;
               end else begin
                  if (fcmp(win_list[i], we.mn) < 0) we.mn = win_list[i];
                  if (fcmp(win_list[i], we.mx) > 0) we.mx = win_list[i];
               end
            end
         end
         we.empty = !have;
         we.cyc   = cyc + 1;
         win_q.push_back(we);
         win_list.delete();
      end
      if (v) begin
         win_list.push_back(d);
         if (is_nan(d) || is_nan(t)) begin
            ce.leq = 0; ce.geq = 0; ce.unord = 1;
         end else begin
            ce.leq   = fcmp(d, t) <= 0;
            ce.geq   = fcmp(d, t) >= 0;
            ce.unord = 0;
         end
         ce.cyc = cyc + 2;
         cmp_q.push_back(ce);
      end
   endtask

   task automatic drive(input bit v, input logic [W-1:0] d, input logic [W-1:0] t, input bit clr);
      step(v, d, t, clr);
      in_valid  = v;
      data_in   = d;
      thresh    = t;
      win_clear = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, '0, '0, 0);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_cmp_valid"}, W'(cmp_valid), '0);
      check({tag, "_leq"},       W'(leq),       '0);
      check({tag, "_geq"},       W'(geq),       '0);
      check({tag, "_unord"},     W'(unord),     '0);
      check({tag, "_win_valid"}, W'(win_valid), '0);
      check({tag, "_win_min"},   win_min,       '0);
      check({tag, "_win_max"},   win_max,       '0);
      check({tag, "_win_empty"}, W'(win_empty), '0);
   endtask

   function automatic logic [W-1:0] rand_val();
      logic [W-1:0] x;
      logic         s;
      s = 1'($urandom);
      case ($urandom_range(0, 7))
         0:       x = '0;
         1:       x = {1'b1, {(W-1){1'b0}}};
         2:       x = {s, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
         3:       x = {s, {EXP_W{1'b1}}, MANT_W'($urandom_range(1, (1 << MANT_W) - 1))};
         4:       x = {s, {EXP_W{1'b0}}, MANT_W'($urandom)};
         default: x = W'($urandom);
      endcase
      return x;
   endfunction

   // Monitor: pops the scoreboard whenever the DUT presents a result.
   always @(negedge clk) begin
      cmp_exp_t ce;
      win_exp_t we;
      if (cmp_valid === 1'b1) begin
         if (cmp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL cmp_unexpected: got cmp_valid=1 expected no result (cycle %0d)", cyc);
         end else begin
            ce = cmp_q.pop_front();
            check("cmp_cycle", W'(cyc), W'(ce.cyc));
            check("leq",   W'(leq),   W'(ce.leq));
            check("geq",   W'(geq),   W'(ce.geq));
            check("unord", W'(unord), W'(ce.unord));
         end
      end
      if (win_valid === 1'b1) begin
         if (win_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL win_unexpected: got win_valid=1 expected no pulse (cycle %0d)", cyc);
         end else begin
            we = win_q.pop_front();
            check("win_cycle", W'(cyc), W'(we.cyc));
            check("win_empty", W'(win_empty), W'(we.empty));
            if (!we.empty) begin
               check("win_min", win_min, we.mn);
               check("win_max", win_max, we.mx);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no completion expected finish");
      $fatal(1);
   end

   initial begin
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      data_in   = '0;
      thresh    = '0;
      win_clear = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Ordering corner cases; these four also close one window.
      drive(1, 32'h3F800000, 32'hBF800000, 0);
      drive(1, 32'hBF800000, 32'h3F800000, 0);
      drive(1, 32'h80000000, 32'h00000000, 0);
      drive(1, 32'h7F800000, 32'h7F7FFFFF, 0);

      // All-NaN window.
      drive(1, 32'h7FC00000, 32'h3F800000, 0);
      for (int i = 0; i < 3; i++) drive(1, 32'h7FC00000, 32'h00000000, 0);

      // Mixed window with a NaN, then the first sample of the next window.
      drive(1, 32'h40000000, 32'h00000000, 0);
      drive(1, 32'hC0400000, 32'h00000000, 0);
      drive(1, 32'h7FC00000, 32'h00000000, 0);
      drive(1, 32'h3F000000, 32'h00000000, 0);
      drive(1, 32'h3F800000, 32'h00000000, 0);

      // Clear with a concurrent sample; the pre-clear -32.0 must not surface.
      drive(1, 32'hC2000000, 32'h00000000, 0);
      drive(1, 32'h41000000, 32'h00000000, 1);
      drive(1, 32'h3F800000, 32'h00000000, 0);
      drive(1, 32'h40000000, 32'h00000000, 0);
      drive(1, 32'h40400000, 32'h00000000, 0);
      idle(4);

      // Reset mid-window after three samples.
      drive(1, 32'h3F800000, 32'h00000000, 0);
      drive(1, 32'hC1000000, 32'h00000000, 0);
      drive(1, 32'h3F800000, 32'h40000000, 0);
      idle(2);
      check("cmp_q_drained", W'(cmp_q.size()), '0);
      reset_n = 1'b0;
      #1;
      check_outputs_zero("midreset");
      win_list.delete();
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      drive(1, 32'h40A00000, 32'h3F800000, 0);
      drive(1, 32'hBF000000, 32'h3F800000, 0);
      drive(1, 32'h00000001, 32'h3F800000, 0);
      drive(1, 32'h80000000, 32'h3F800000, 0);
      idle(3);

      // Randomized traffic with occasional clears.
      for (int i = 0; i < 400; i++) begin
         logic [W-1:0] d, t;
         d = rand_val();
         t = ($urandom_range(0, 9) == 0) ? d : rand_val();
         drive($urandom_range(0, 3) != 0, d, t, $urandom_range(0, 11) == 0);
      end

      // Drain, bounded.
      for (int i = 0; i < 20 && (cmp_q.size() != 0 || win_q.size() != 0 || win_list.size() == WINDOW); i++)
         idle(1);
      idle(2);
      check("final_cmp_q_empty", W'(cmp_q.size()), '0);
      check("final_win_q_empty", W'(win_q.size()), '0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
